alarm_pulse_strobe: RTL and testbench
=====================================

ALARM_PULSE_STROBE -- requirements
Module: alarm_pulse_strobe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 value  input  8  load value shared by all three channels.
REQ-005 put_alarm, put_pulse, put_strobe  input  1 each  per-channel synchronous load strobe, sampled on rising edge.
REQ-006 init_alarm, init_pulse, init_strobe  input  8 each  per-channel count loaded during reset; static inputs.
REQ-007 bell  output  1  alarm one-shot expiry pulse.
REQ-008 act  output  1  pulse-channel active window.
REQ-009 beep  output  1  strobe periodic tick.

Function
REQ-010 Each channel SHALL hold an independent 8-bit down-counter.
REQ-011 Alarm counter: on put_alarm, cnt<=value; else if cnt!=0, cnt<=cnt-1; else hold.
REQ-012 Alarm output: bell is registered; bell<=1 exactly on the edge where cnt goes 1->0 by decrement, else bell<=0.
REQ-013 Alarm timing: put_alarm at edge k with value V>0 -> bell high for one cycle after edge k+V; V=0 -> no bell.
REQ-014 Pulse counter: on put_pulse, cnt<=value; else if cnt!=0, cnt<=cnt-1.
REQ-015 Pulse output: act=(cnt!=0)&&!reset, driven directly from the counter register with no extra logic delay.
REQ-016 Pulse timing: put_pulse at edge k with V>0 -> act high from edge k to edge k+V, i.e. V cycles.
REQ-017 Strobe state: 8-bit period register per and 8-bit counter cnt.
REQ-018 Strobe load: on put_strobe, per<=value and cnt<=value.
REQ-019 Strobe count step, when put_strobe is low and per!=0: if cnt<=1, cnt<=per and beep<=1; else cnt<=cnt-1 and beep<=0.
REQ-020 Strobe disable: per==0 -> beep<=0 and counter held.
REQ-021 Strobe timing: load at edge k with P>0 -> one-cycle beep after edges k+P, k+2P, ...
REQ-022 Strobe period of 1 SHALL keep beep high continuously.
REQ-023 Restart: a put while a channel is active SHALL restart that channel from the new value; the old count is discarded.
REQ-024 A put on the same edge as a would-be expiry or tick SHALL take priority; bell/beep are 0 after that edge.
REQ-025 A put with value 0 SHALL cancel the channel: bell/act/beep are low after that edge.
REQ-026 put and value SHALL be treated as synchronous, and arithmetic SHALL be unsigned 8-bit with no wrap below 0.

Reset
REQ-027 While reset is high, alarm cnt<=init_alarm, pulse cnt<=init_pulse, strobe per<=init_strobe and cnt<=init_strobe.
REQ-028 While reset is high, bell, act and beep SHALL all be 0.
REQ-029 Counting SHALL begin on the first rising edge after reset falls.
REQ-030 Nonzero init values SHALL run exactly as if loaded by a put at the reset release.
REQ-031 Reset asserted mid-operation SHALL immediately and asynchronously reinitialise every channel.

Verification
REQ-032 Scenario, free-running strobe: init_strobe=5, all puts 0, reset released -> beep one cycle every 5 cycles, first on the 5th edge after release.
REQ-033 Scenario, alarm: value=0x11, put_alarm for 1 cycle at edge k -> bell high only in cycle after edge k+17.
REQ-034 Scenario, pulse: value=0x11, put_pulse at edge k -> act high for exactly 17 cycles, then low.
REQ-035 Scenario, restart: put at edge k, second put 4 cycles later with value=0x11 -> bell at k+4+17, act ends at k+4+17, beep at k+4+17.
REQ-036 Scenario, reload: strobe loaded 0x11, then value changes to 0x07 without put -> period stays 17.
REQ-037 Scenario, cancel and reset: put value=0 cancels all outputs next edge; reset mid-count -> outputs 0 at once, counters return to init values.

Source files
------------

// File: rtl/alarm_pulse_strobe.sv
// Three independent 8-bit down-counter timers sharing one load value: one-shot alarm (bell), active window (act), periodic strobe (beep).
// bell/beep are registered one edge after the deciding count; act is the live counter state; no backpressure, puts always accepted.
module alarm_pulse_strobe (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] value,
   input  logic       put_alarm,
   input  logic       put_pulse,
   input  logic       put_strobe,
   input  logic [7:0] init_alarm,
   input  logic [7:0] init_pulse,
   input  logic [7:0] init_strobe,
   output logic       bell,
   output logic       act,
   output logic       beep
);

   logic [7:0] alarm_cnt;
   logic [7:0] alarm_nxt;
   logic       bell_nxt;

   logic [7:0] pulse_cnt;
   logic [7:0] pulse_nxt;

   logic [7:0] strobe_per;
   logic [7:0] strobe_cnt;
   logic [7:0] strobe_per_nxt;
   logic [7:0] strobe_cnt_nxt;
   logic       beep_nxt;

   // Alarm: a put always wins over the 1->0 expiry on the same edge.
   always_comb begin
      alarm_nxt = alarm_cnt;
      bell_nxt  = 1'b0;
      if (put_alarm) begin
         alarm_nxt = value;
      end else if (alarm_cnt != 8'd0) begin
         alarm_nxt = alarm_cnt - 8'd1;
         bell_nxt  = (alarm_cnt == 8'd1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         alarm_cnt <= init_alarm;
         bell      <= 1'b0;
      end else begin
         alarm_cnt <= alarm_nxt;
         bell      <= bell_nxt;
      end
   end

   always_comb begin
      pulse_nxt = pulse_cnt;
      if (put_pulse) begin
         pulse_nxt = value;
      end else if (pulse_cnt != 8'd0) begin
         pulse_nxt = pulse_cnt - 8'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pulse_cnt <= init_pulse;
      end else begin
         pulse_cnt <= pulse_nxt;
      end
   end

   // act is masked by reset so it drops the instant reset rises.
   assign act = (pulse_cnt != 8'd0) && !reset;

   // Strobe: the counter reloads from the period on the tick edge, so a period of 1 ticks every edge.
   always_comb begin
      strobe_per_nxt = strobe_per;
      strobe_cnt_nxt = strobe_cnt;
      beep_nxt       = 1'b0;
      if (put_strobe) begin
         strobe_per_nxt = value;
         strobe_cnt_nxt = value;
      end else if (strobe_per != 8'd0) begin
         if (strobe_cnt <= 8'd1) begin
            strobe_cnt_nxt = strobe_per;
            beep_nxt       = 1'b1;
         end else begin
            strobe_cnt_nxt = strobe_cnt - 8'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         strobe_per <= init_strobe;
         strobe_cnt <= init_strobe;
         beep       <= 1'b0;
      end else begin
         strobe_per <= strobe_per_nxt;
         strobe_cnt <= strobe_cnt_nxt;
         beep       <= beep_nxt;
      end
   end

endmodule

// File: tb/tb_alarm_pulse_strobe.sv
// Bench for alarm_pulse_strobe: directed scenarios plus random puts/resets against an event-time reference model.
module tb_alarm_pulse_strobe;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] value;
   logic       put_alarm, put_pulse, put_strobe;
   logic [7:0] init_alarm, init_pulse, init_strobe;
   logic       bell, act, beep;

   int tests = 0;
   int fails = 0;

   // Model: n counts edges since the last load point; each channel remembers its load edge and value.
   int n;
   int a_org, a_v, p_org, p_v, s_org, s_p;

   always #5 clock = ~clock;

   alarm_pulse_strobe dut (
      .clock       (clock),
      .reset       (reset),
      .value       (value),
      .put_alarm   (put_alarm),
      .put_pulse   (put_pulse),
      .put_strobe  (put_strobe),
      .init_alarm  (init_alarm),
      .init_pulse  (init_pulse),
      .init_strobe (init_strobe),
      .bell        (bell),
      .act         (act),
      .beep        (beep)
   );

   task automatic check_outputs(input string tag);
      logic eb, ea, es;
      eb = (a_v > 0) && (n == a_org + a_v);
      ea = (n < p_org + p_v);
      es = (s_p > 0) && (n > s_org) && (((n - s_org) % s_p) == 0);
      tests += 3;
      assert (bell === eb) else begin
         fails++;
         $error("FAIL %s bell n=%0d got %b expected %b", tag, n, bell, eb);
      end
      assert (act === ea) else begin
         fails++;
         $error("FAIL %s act n=%0d got %b expected %b", tag, n, act, ea);
      end
      assert (beep === es) else begin
         fails++;
         $error("FAIL %s beep n=%0d got %b expected %b", tag, n, beep, es);
      end
   endtask

   task automatic check_zero(input string tag);
      tests += 3;
      assert (bell === 1'b0) else begin
         fails++;
         $error("FAIL %s bell got %b expected 0", tag, bell);
      end
      assert (act === 1'b0) else begin
         fails++;
         $error("FAIL %s act got %b expected 0", tag, act);
      end
      assert (beep === 1'b0) else begin
         fails++;
         $error("FAIL %s beep got %b expected 0", tag, beep);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clock);
      n++;
      if (put_alarm)  begin a_org = n; a_v = int'(value); end
      if (put_pulse)  begin p_org = n; p_v = int'(value); end
      if (put_strobe) begin s_org = n; s_p = int'(value); end
      #1;
      check_outputs(tag);
   endtask

   task automatic steps(input int k, input string tag);
      for (int i = 0; i < k; i++) step(tag);
   endtask

   task automatic put(input logic a, input logic p, input logic s, input logic [7:0] v, input string tag);
      put_alarm  = a;
      put_pulse  = p;
      put_strobe = s;
      value      = v;
      step(tag);
      put_alarm  = 1'b0;
      put_pulse  = 1'b0;
      put_strobe = 1'b0;
   endtask

   // Called just after an edge; hold=0 pulses reset between edges.
   task automatic do_reset(input logic [7:0] ia, input logic [7:0] ip, input logic [7:0] is,
                           input int hold, input string tag);
      init_alarm  = ia;
      init_pulse  = ip;
      init_strobe = is;
      reset       = 1'b1;
      #1;
      check_zero(tag);
      for (int i = 0; i < hold; i++) begin
         @(posedge clock);
         #1;
         check_zero(tag);
      end
      #1;
      reset = 1'b0;
      n     = 0;
      a_org = 0; a_v = int'(ia);
      p_org = 0; p_v = int'(ip);
      s_org = 0; s_p = int'(is);
   endtask

   initial begin
      reset       = 1'b1;
      value       = 8'd0;
      put_alarm   = 1'b0;
      put_pulse   = 1'b0;
      put_strobe  = 1'b0;
      init_alarm  = 8'd0;
      init_pulse  = 8'd0;
      init_strobe = 8'd0;
      n = 0; a_org = 0; a_v = 0; p_org = 0; p_v = 0; s_org = 0; s_p = 0;
      @(posedge clock);
      #1;

      // Free-running strobe from init, first beep on 5th edge after release.
      do_reset(8'd0, 8'd0, 8'd5, 2, "reset_state");
      steps(16, "strobe_init5");

      do_reset(8'd0, 8'd0, 8'd0, 1, "reset_quiet");
      steps(2, "idle");
      put(1'b1, 1'b0, 1'b0, 8'h11, "alarm_load");
      steps(20, "alarm_run");

      put(1'b0, 1'b1, 1'b0, 8'h11, "pulse_load");
      steps(20, "pulse_run");

      // Restart all channels 4 cycles after the first put.
      put(1'b1, 1'b1, 1'b1, 8'd9, "restart_first");
      steps(3, "restart_gap");
      put(1'b1, 1'b1, 1'b1, 8'h11, "restart_second");
      steps(40, "restart_run");

      // Changing value without a put must not disturb the strobe period.
      value = 8'h07;
      steps(40, "reload_nochange");

      put(1'b0, 1'b0, 1'b1, 8'd1, "strobe_p1_load");
      steps(6, "strobe_p1_run");

      // Cancel with value 0 on the would-be expiry edge.
      put(1'b1, 1'b1, 1'b1, 8'd3, "cancel_load");
      steps(2, "cancel_wait");
      put(1'b1, 1'b1, 1'b1, 8'd0, "cancel_put");
      steps(8, "cancel_after");

      // Reset mid-count returns channels to their init values.
      put(1'b1, 1'b1, 1'b1, 8'd30, "mid_load");
      steps(5, "mid_run");
      do_reset(8'd4, 8'd6, 8'd3, 0, "mid_reset");
      steps(15, "post_reset");
      do_reset(8'd1, 8'd1, 8'd1, 2, "init_one");
      steps(4, "init_one_run");

      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset(8'($urandom_range(0, 25)), 8'($urandom_range(0, 25)),
                     8'($urandom_range(0, 12)), $urandom_range(0, 2), "rand_reset");
         end else begin
            put_alarm  = ($urandom_range(0, 14) == 0);
            put_pulse  = ($urandom_range(0, 14) == 0);
            put_strobe = ($urandom_range(0, 24) == 0);
            value      = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(0, 20));
            step("rand");
            put_alarm  = 1'b0;
            put_pulse  = 1'b0;
            put_strobe = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
